// File: rtl/mem_access.sv
// MEM pipeline stage: byte-serial little-endian load/store over a byte-wide synchronous RAM,
// stalling the pipeline for the duration of each access and passing ALU results straight through.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic              is_load_i,
    input  logic              stall_i,
    input  logic [7:0]        ram_din_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stallreq_o
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [31:0] buffer;

    logic        mem_op;
    logic        is_load;
    logic        sign_ext;
    logic [2:0]  nbytes;
    logic        last_step;
    logic [7:0]  store_byte_next;
    logic [31:0] load_data;

    // aluop supplies width and extension; EX's is_load flag supplies the direction.
    always_comb begin
        mem_op   = 1'b1;
        nbytes   = 3'd1;
        sign_ext = 1'b0;
        case (aluop_i)
            EXE_LB_OP:  sign_ext = 1'b1;
            EXE_LBU_OP: ;
            EXE_SB_OP:  ;
            EXE_LH_OP:  begin nbytes = 3'd2; sign_ext = 1'b1; end
            EXE_LHU_OP: nbytes = 3'd2;
            EXE_SH_OP:  nbytes = 3'd2;
            EXE_LW_OP:  nbytes = 3'd4;
            EXE_SW_OP:  nbytes = 3'd4;
            default:    mem_op = 1'b0;
        endcase
        is_load = mem_op & is_load_i;
    end

    // Loads need one extra step because read data trails its address by a cycle.
    always_comb begin
        last_step = is_load ? (cnt == nbytes) : (cnt == nbytes - 3'd1);
        case (cnt)
            3'd0:    store_byte_next = reg2_i[15:8];
            3'd1:    store_byte_next = reg2_i[23:16];
            default: store_byte_next = reg2_i[31:24];
        endcase
        case (nbytes)
            3'd1:    load_data = {{24{sign_ext & buffer[7]}}, buffer[7:0]};
            3'd2:    load_data = {{16{sign_ext & buffer[15]}}, buffer[15:0]};
            default: load_data = buffer;
        endcase
    end

    always_comb begin
        state_next = state;
        stallreq_o = 1'b0;
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stallreq_o = 1'b1;
                    wreg_o     = 1'b0;
                    wdata_o    = 32'h0;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
                wdata_o    = 32'h0;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                if (is_load) wdata_o = load_data;
                if (!stall_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            stallreq_o = 1'b0;
            wd_o       = 5'd0;
            wreg_o     = 1'b0;
            wdata_o    = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            buffer     <= 32'h0;
            ram_addr_o <= '0;
            ram_wr_o   <= 1'b0;
            ram_dout_o <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        ram_addr_o <= mem_addr_i[ADDR_W-1:0];
                        cnt        <= 3'd0;
                        ram_wr_o   <= !is_load;
                        if (!is_load) ram_dout_o <= reg2_i[7:0];
                    end
                end
                ACCESS: begin
                    if (is_load) begin
                        case (cnt)
                            3'd1:    buffer[7:0]   <= ram_din_i;
                            3'd2:    buffer[15:8]  <= ram_din_i;
                            3'd3:    buffer[23:16] <= ram_din_i;
                            3'd4:    buffer[31:24] <= ram_din_i;
                            default: ;
                        endcase
                        if (!last_step) cnt <= cnt + 3'd1;
                        if (cnt < nbytes - 3'd1) ram_addr_o <= ram_addr_o + ADDR_W'(1);
                    end else if (last_step) begin
                        ram_wr_o <= 1'b0;
                    end else begin
                        cnt        <= cnt + 3'd1;
                        ram_addr_o <= ram_addr_o + ADDR_W'(1);
                        ram_dout_o <= store_byte_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random ops against a byte-array
// reference model of memory, with a synchronous byte RAM attached to the DUT.
module tb_mem_access;

    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic        is_load_i;
    logic        stall_i;
    logic [7:0]  ram_din;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    logic        ram_clear;
    logic [7:0]  ram [4096];
    logic [7:0]  ref_mem [4096];

    int checks = 0;
    int errors = 0;

    mem_access #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .is_load_i  (is_load_i),
        .stall_i    (stall_i),
        .ram_din_i  (ram_din),
        .ram_addr_o (ram_addr_o),
        .ram_wr_o   (ram_wr_o),
        .ram_dout_o (ram_dout_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte RAM; the low 12 address bits select a byte so wrapped addresses stay distinct.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        end else if (ram_wr_o) begin
            ram[ram_addr_o[11:0]] <= ram_dout_o;
        end
        ram_din <= ram[ram_addr_o[11:0]];
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic void classify(input logic [7:0] op, output bit mem, output bit ld,
                                     output int n, output bit sgn);
        mem = 1'b1; ld = 1'b0; n = 1; sgn = 1'b0;
        case (op)
            OP_LB:   begin ld = 1'b1; sgn = 1'b1; end
            OP_LBU:  ld = 1'b1;
            OP_LH:   begin ld = 1'b1; sgn = 1'b1; n = 2; end
            OP_LHU:  begin ld = 1'b1; n = 2; end
            OP_LW:   begin ld = 1'b1; n = 4; end
            OP_SB:   ;
            OP_SH:   n = 2;
            OP_SW:   n = 4;
            default: mem = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input bit sgn);
        logic [31:0] a;
        logic [31:0] val;
        val = 32'h0;
        for (int k = 0; k < n; k++) begin
            a = addr + k;
            val = val | (32'(ref_mem[a[11:0]]) << (8 * k));
        end
        if (sgn && n == 1 && val[7])  val = val | 32'hFFFF_FF00;
        if (sgn && n == 2 && val[15]) val = val | 32'hFFFF_0000;
        return val;
    endfunction

    // Drives one op at the start of a cycle and checks every cycle until it has retired.
    task automatic apply_stimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                  input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                                  input int hold);
        bit          mem, ld, sgn;
        int          n, lat;
        logic [31:0] exp_data, a;
        classify(op, mem, ld, n, sgn);
        lat      = !mem ? 0 : (ld ? n + 2 : n + 1);
        exp_data = (mem && ld) ? model_load(addr, n, sgn) : wdata;
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = wdata;
        wd_i = wd; wreg_i = wreg; is_load_i = ld; stall_i = 1'b0;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            check_output($sformatf("op%02h c%0d stallreq", op, c), 32'(stallreq_o), 32'(c < lat));
            check_output($sformatf("op%02h c%0d ram_wr", op, c), 32'(ram_wr_o),
                         32'(mem && !ld && c >= 1 && c <= n));
            if (mem && c >= 1 && c <= n) begin
                a = addr + c - 1;
                check_output($sformatf("op%02h c%0d ram_addr", op, c), ram_addr_o, a);
                if (!ld)
                    check_output($sformatf("op%02h c%0d ram_dout", op, c), 32'(ram_dout_o),
                                 (reg2 >> (8 * (c - 1))) & 32'hFF);
            end
            if (c == lat) begin
                check_output($sformatf("op%02h wdata", op), wdata_o, exp_data);
                check_output($sformatf("op%02h wd", op), 32'(wd_o), 32'(wd));
                check_output($sformatf("op%02h wreg", op), 32'(wreg_o), 32'(wreg));
                if (hold > 0) stall_i = 1'b1;
            end
            @(posedge clk); #1;
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            a = addr + n - 1;
            check_output($sformatf("hold%0d stallreq", h), 32'(stallreq_o), 32'h0);
            check_output($sformatf("hold%0d ram_wr", h), 32'(ram_wr_o), 32'h0);
            check_output($sformatf("hold%0d wdata", h), wdata_o, exp_data);
            check_output($sformatf("hold%0d ram_addr", h), ram_addr_o, a);
            if (h == hold) stall_i = 1'b0;
            @(posedge clk); #1;
        end
        if (mem && !ld) begin
            for (int k = 0; k < n; k++) begin
                a = addr + k;
                ref_mem[a[11:0]] = 8'((reg2 >> (8 * k)) & 32'hFF);
            end
        end
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] addr;
        bit          mem, ld, sgn;
        int          n, hold;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        rst = 1'b1; ram_clear = 1'b1; stall_i = 1'b0;
        aluop_i = OP_LW; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        mem_addr_i = 32'h0000_0040; reg2_i = 32'h0; is_load_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset ram_addr", ram_addr_o, 32'h0);
        check_output("reset ram_wr", 32'(ram_wr_o), 32'h0);
        check_output("reset ram_dout", 32'(ram_dout_o), 32'h0);
        check_output("reset stallreq", 32'(stallreq_o), 32'h0);
        check_output("reset wd", 32'(wd_o), 32'h0);
        check_output("reset wreg", 32'(wreg_o), 32'h0);
        check_output("reset wdata", wdata_o, 32'h0);
        aluop_i = OP_ADD; is_load_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; ram_clear = 1'b0;

        $display("[TB] directed cases");
        apply_stimulus(OP_ADD, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 0);
        apply_stimulus(OP_SW, 32'h0000_0100, 32'hA1B2_C3D4, 32'h0, 5'd0, 1'b0, 0);
        apply_stimulus(OP_SB, 32'h0000_0200, 32'h0000_0080, 32'h0, 5'd0, 1'b0, 0);
        apply_stimulus(OP_SB, 32'h0000_0201, 32'h0000_007F, 32'h0, 5'd0, 1'b0, 0);
        apply_stimulus(OP_LB, 32'h0000_0200, 32'h0, 32'h0, 5'd3, 1'b1, 0);
        apply_stimulus(OP_LBU, 32'h0000_0200, 32'h0, 32'h0, 5'd4, 1'b1, 0);
        apply_stimulus(OP_LH, 32'h0000_0200, 32'h0, 32'h0, 5'd6, 1'b1, 0);
        apply_stimulus(OP_SW, 32'hFFFF_FFFE, 32'h4433_2211, 32'h0, 5'd0, 1'b0, 0);
        apply_stimulus(OP_LW, 32'hFFFF_FFFE, 32'h0, 32'h0, 5'd9, 1'b1, 0);
        apply_stimulus(OP_LW, 32'h0000_0100, 32'h0, 32'h0, 5'd10, 1'b1, 3);

        // Reset lands while the third store byte is on the RAM port.
        aluop_i = OP_SW; mem_addr_i = 32'h0000_0100; reg2_i = 32'h5566_7788; is_load_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_output("midrst byte1 addr", ram_addr_o, 32'h0000_0101);
        check_output("midrst byte1 wr", 32'(ram_wr_o), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        aluop_i = OP_ADD;
        #1;
        check_output("midrst ram_wr", 32'(ram_wr_o), 32'h0);
        check_output("midrst stallreq", 32'(stallreq_o), 32'h0);
        check_output("midrst wdata", wdata_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[12'h100] = 8'h88;
        ref_mem[12'h101] = 8'h77;
        apply_stimulus(OP_LW, 32'h0000_0100, 32'h0, 32'h0, 5'd11, 1'b1, 0);

        $display("[TB] random cases");
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0: op = OP_LB;  1: op = OP_LBU; 2: op = OP_LH;  3: op = OP_LHU;
                4: op = OP_LW;  5: op = OP_SB;  6: op = OP_SH;  7: op = OP_SW;
                8: op = OP_ADD;
                default: op = 8'($urandom_range(0, 255));
            endcase
            classify(op, mem, ld, n, sgn);
            hold = mem ? $urandom_range(0, 2) : 0;
            addr = 32'h0000_0300 + $urandom_range(0, 255);
            apply_stimulus(op, addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
                           1'($urandom_range(0, 1)), hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
